sigma_timer: RTL and testbench
==============================

// Module: sigma_timer
//
// PURPOSE
// Memory-mapped 32-bit timer/compare peripheral on the sigma tile's xbus, next to the LED/SW CSR block.
// - Decodes its own address window, counts clock ticks and flags a compare match.
// - Drives a level interrupt the top level ORs with the debounced button IRQ.
// - xbus protocol: request accepted in the cycle it is presented; read data returned one cycle later.
//
// PARAMETERS
// BASE_ADDR   32'h80000100  byte address of register window (16-byte aligned, 32 bytes decoded)
// CMP_RESET   32'hFFFFFFFF  reset value of COMPARE
//
// PORTS
// clk_i         in   1   system clock
// rst_i         in   1   synchronous active-high reset
// bus_req_i     in   1   xbus request
// bus_we_i      in   1   1=write, 0=read
// bus_addr_bi   in   32  byte address
// bus_be_bi     in   4   byte enables (writes)
// bus_wdata_bi  in   32  write data
// bus_ack_o     out  1   request accepted
// bus_resp_o    out  1   read response valid
// bus_rdata_bo  out  32  read data
// irq_o         out  1   timer interrupt, level
//
// BEHAVIOUR
// Register map, offsets from BASE_ADDR:
// - 0x00 CTRL: [0] EN, [1] AUTORELOAD, [2] IRQ_EN; other bits read 0.
// - 0x04 COUNT.
// - 0x08 COMPARE.
// - 0x0C STATUS: [0] MATCH; write 1 clears.
// - 0x10 PRESC: see CONFIGURATION.
// - 0x14-0x1F: reserved, read 0.
// Reset values:
// - All registers 0, except COMPARE = CMP_RESET.
// - bus_resp_o=0, bus_rdata_bo=0, irq_o=0.
// Bus:
// - bus_ack_o = bus_req_i, combinational; the block never stalls.
// - Writes: bytes with bus_be_bi[i]=1 update; no resp is generated for writes.
// - Reads inside the window: bus_resp_o=1 exactly one cycle after acceptance.
//   bus_rdata_bo carries the register value sampled in the accept cycle.
//   bus_rdata_bo is 0 whenever bus_resp_o=0.
// - Requests outside the window: ignored, no resp.
// - Back-to-back reads: one resp per cycle, in order.
// Count engine:
// - Acts only when EN=1 and tick=1.
// - If COUNT==COMPARE: MATCH<=1. Then:
//   - AUTORELOAD=1: COUNT<=0.
//   - AUTORELOAD=0: COUNT holds and EN<=0 (one-shot).
// - Otherwise COUNT<=COUNT+1, wrapping 0xFFFFFFFF->0 modulo 2^32; wrap alone does not set MATCH.
// - COMPARE is written while running: the new value applies from the next cycle.
// Simultaneous events:
// - Bus write to COUNT or CTRL in the same cycle as an engine update: the bus write wins for written bytes.
// - MATCH set and W1C in the same cycle: set wins.
// irq_o:
// - irq_o = MATCH & IRQ_EN, registered; 1-cycle lag from MATCH/IRQ_EN change.
// - Reset mid-count returns everything to reset values next edge; a pending resp is dropped.
//
// CONFIGURATION
// SIGMA_TIMER_PRESCALER_EN defined:
// - PRESC[15:0] is read/write, with an internal 16-bit prescale counter.
// - tick=1 when prescale counter == PRESC; the counter then returns to 0, otherwise increments while EN=1.
// - EN=0 or a write to PRESC clears the prescale counter. PRESC=0 gives a tick every cycle.
// SIGMA_TIMER_PRESCALER_EN undefined:
// - tick=1 every cycle.
// - 0x10 reads 0, writes are ignored, and resp is still returned.
//
// TESTING
// - Reset, then read 0x08 -> resp 1 cycle later, rdata=0xFFFFFFFF. Read 0x00, 0x04, 0x0C -> 0.
// - COMPARE=5, CTRL=0x7 -> after 6 active ticks MATCH=1, irq_o=1 one cycle later, COUNT reloads to 0 and repeats.
//   Write STATUS=1 -> irq_o=0.
// - CTRL=0x1, COMPARE=3 -> COUNT stops at 3, EN reads 0, MATCH=1, irq_o stays 0 (IRQ_EN=0).
// - COUNT=0xFFFFFFFE, COMPARE=0x10, EN=1 -> COUNT goes 0xFFFFFFFF, 0, 1, ... with no MATCH at wrap.
//   Partial write be=4'b0001 of 0xAA -> only COUNT[7:0] changes.
// - W1C on STATUS in the same cycle as a match -> MATCH stays 1.
//   Read at BASE_ADDR+0x40 -> ack=1, no resp. Reads on 3 consecutive cycles -> 3 in-order resps.
// - With SIGMA_TIMER_PRESCALER_EN: PRESC=3, COMPARE=2, auto-reload -> MATCH after 12 cycles.
//   Without the macro: PRESC reads 0 after writing 3.

Source files
------------

// File: rtl/sigma_timer.sv
`default_nettype none
// ============================================================================
// Module   : sigma_timer
// Purpose  : xbus-mapped 32-bit timer with compare match and level interrupt.
//            Optional prescaler enabled by defining SIGMA_TIMER_PRESCALER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sigma_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h80000100,
   parameter logic [31:0] CMP_RESET = 32'hFFFFFFFF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        bus_req_i,
   input  logic        bus_we_i,
   input  logic [31:0] bus_addr_bi,
   input  logic [3:0]  bus_be_bi,
   input  logic [31:0] bus_wdata_bi,
   output logic        bus_ack_o,
   output logic        bus_resp_o,
   output logic [31:0] bus_rdata_bo,
   output logic        irq_o
);

   localparam logic [2:0] c_REG_CTRL   = 3'd0;
   localparam logic [2:0] c_REG_COUNT  = 3'd1;
   localparam logic [2:0] c_REG_CMP    = 3'd2;
   localparam logic [2:0] c_REG_STATUS = 3'd3;
   localparam logic [2:0] c_REG_PRESC  = 3'd4;

   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] count_q, count_d;
   logic [31:0] cmp_q, cmp_d;
   logic        match_q, match_d;
   logic        irq_q;
   logic        resp_q;
   logic [31:0] rdata_q;

   logic [31:0] w_off;
   logic        w_in_win;
   logic [2:0]  w_idx;
   logic        w_wr;
   logic        w_rd;
   logic        w_wr_presc;
   logic        w_tick;
   logic [31:0] w_presc_rd;
   logic [31:0] w_rd_val;
   logic        unused_ok;

   function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
      end
      return res;
   endfunction

   // Subtracting the base keeps decode correct for any 16-byte aligned window.
   assign w_off      = bus_addr_bi - BASE_ADDR;
   assign w_in_win   = (w_off[31:5] == 27'd0);
   assign w_idx      = w_off[4:2];
   assign w_wr       = bus_req_i & bus_we_i & w_in_win;
   assign w_rd       = bus_req_i & ~bus_we_i & w_in_win;
   assign w_wr_presc = w_wr & (w_idx == c_REG_PRESC);
   assign unused_ok  = ^{1'b0, w_off[1:0]};

   assign bus_ack_o    = bus_req_i;
   assign bus_resp_o   = resp_q;
   assign bus_rdata_bo = rdata_q;
   assign irq_o        = irq_q;

`ifdef SIGMA_TIMER_PRESCALER_EN
   logic [15:0] presc_q;
   logic [15:0] pcnt_q;

   assign w_tick     = (pcnt_q == presc_q);
   assign w_presc_rd = {16'h0000, presc_q};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         presc_q <= 16'h0000;
         pcnt_q  <= 16'h0000;
      end else begin
         if (w_wr_presc) begin
            presc_q <= merge_be({16'h0000, presc_q}, bus_wdata_bi, bus_be_bi)
                       [15:0];
         end
         if (!ctrl_q[0] || w_wr_presc || w_tick) begin
            pcnt_q <= 16'h0000;
         end else begin
            pcnt_q <= pcnt_q + 16'd1;
         end
      end
   end
`else
   assign w_tick     = 1'b1;
   assign w_presc_rd = 32'h0000_0000;
`endif

   always_comb begin
      ctrl_d  = ctrl_q;
      count_d = count_q;
      cmp_d   = cmp_q;
      match_d = match_q;

      if (ctrl_q[0] && w_tick) begin
         if (count_q == cmp_q) begin
            if (ctrl_q[1]) begin
               count_d = 32'h0000_0000;
            end else begin
               ctrl_d[0] = 1'b0;
            end
         end else begin
            count_d = count_q + 32'd1;
         end
      end

      // Bus writes are applied after the engine so they win on written bytes.
      if (w_wr && (w_idx == c_REG_CTRL) && bus_be_bi[0]) begin
         ctrl_d = bus_wdata_bi[2:0];
      end
      if (w_wr && (w_idx == c_REG_COUNT)) begin
         count_d = merge_be(count_d, bus_wdata_bi, bus_be_bi);
      end
      if (w_wr && (w_idx == c_REG_CMP)) begin
         cmp_d = merge_be(cmp_q, bus_wdata_bi, bus_be_bi);
      end
      if (w_wr && (w_idx == c_REG_STATUS) && bus_be_bi[0] && bus_wdata_bi[0]) begin
         match_d = 1'b0;
      end
      if (ctrl_q[0] && w_tick && (count_q == cmp_q)) begin
         match_d = 1'b1;
      end
   end

   always_comb begin
      w_rd_val = 32'h0000_0000;
      case (w_idx)
         c_REG_CTRL:   w_rd_val = {29'd0, ctrl_q};
         c_REG_COUNT:  w_rd_val = count_q;
         c_REG_CMP:    w_rd_val = cmp_q;
         c_REG_STATUS: w_rd_val = {31'd0, match_q};
         c_REG_PRESC:  w_rd_val = w_presc_rd;
         default:      w_rd_val = 32'h0000_0000;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl_q  <= 3'd0;
         count_q <= 32'h0000_0000;
         cmp_q   <= CMP_RESET;
         match_q <= 1'b0;
         irq_q   <= 1'b0;
         resp_q  <= 1'b0;
         rdata_q <= 32'h0000_0000;
      end else begin
         ctrl_q  <= ctrl_d;
         count_q <= count_d;
         cmp_q   <= cmp_d;
         match_q <= match_d;
         irq_q   <= match_q & ctrl_q[2];
         resp_q  <= w_rd;
         rdata_q <= w_rd ? w_rd_val : 32'h0000_0000;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sigma_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigma_timer
// Purpose  : Directed self-checking bench for sigma_timer with a read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigma_timer;

   localparam logic [31:0] BASE = 32'h80000100;

   logic        clk = 1'b0;
   logic        rst;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic        bus_resp;
   logic [31:0] bus_rdata;
   logic        irq;

   typedef struct {
      logic [31:0] exp;
      logic [7:0]  off;
   } rd_t;

   rd_t sb[$];
   int  compared   = 0;
   int  mismatched = 0;

   sigma_timer #(
      .BASE_ADDR (BASE),
      .CMP_RESET (32'hFFFFFFFF)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .bus_req_i    (bus_req),
      .bus_we_i     (bus_we),
      .bus_addr_bi  (bus_addr),
      .bus_be_bi    (bus_be),
      .bus_wdata_bi (bus_wdata),
      .bus_ack_o    (bus_ack),
      .bus_resp_o   (bus_resp),
      .bus_rdata_bo (bus_rdata),
      .irq_o        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_req = 1'b0;
      bus_we  = 1'b0;
   endtask

   task automatic cyc(input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] d);
      bus_req   = 1'b1;
      bus_we    = we;
      bus_addr  = addr;
      bus_be    = be;
      bus_wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] be);
      cyc(1'b1, BASE + {24'd0, off}, be, d);
      idle();
   endtask

   task automatic rd_push(input logic [7:0] off, input logic [31:0] exp);
      rd_t e;
      e.exp = exp;
      e.off = off;
      sb.push_back(e);
      cyc(1'b0, BASE + {24'd0, off}, 4'h0, 32'h0);
   endtask

   task automatic rd(input logic [7:0] off, input logic [31:0] exp);
      rd_push(off, exp);
      idle();
   endtask

   always @(negedge clk) begin : mon
      rd_t e;
      if (rst === 1'b0) begin
         if (bus_resp === 1'b1) begin
            compared++;
            assert (sb.size() != 0) else begin
               mismatched++;
               $error("FAIL resp_unexpected: observed resp=1 expected resp=0");
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk($sformatf("rdata_off_%02h", e.off), bus_rdata, e.exp);
            end
         end else begin
            chk("rdata_idle", bus_rdata, 32'h0);
         end
      end
   end

   initial begin
      rst = 1'b1;
      idle();
      bus_addr  = 32'h0;
      bus_be    = 4'h0;
      bus_wdata = 32'h0;
      wait_cycles(3);
      rst = 1'b0;
      chk("reset_irq", {31'd0, irq}, 32'd0);
      chk("reset_resp", {31'd0, bus_resp}, 32'd0);
      chk("reset_rdata", bus_rdata, 32'd0);

      // Reset values
      rd(8'h08, 32'hFFFFFFFF);
      rd(8'h00, 32'h0);
      rd(8'h04, 32'h0);
      rd(8'h0C, 32'h0);

      // Auto-reload with interrupt
      wr(8'h08, 32'd5, 4'hF);
      wr(8'h00, 32'h7, 4'hF);
      wait_cycles(5);
      rd(8'h04, 32'd5);
      chk("ar_irq_before", {31'd0, irq}, 32'd0);
      wait_cycles(1);
      chk("ar_irq_set", {31'd0, irq}, 32'd1);
      rd(8'h0C, 32'd1);
      wr(8'h0C, 32'd1, 4'hF);
      chk("ar_irq_lag", {31'd0, irq}, 32'd1);
      wait_cycles(1);
      chk("ar_irq_clr", {31'd0, irq}, 32'd0);
      rd(8'h04, 32'd4);
      wait_cycles(1);
      rd(8'h0C, 32'd1);
      wr(8'h00, 32'h0, 4'hF);
      wr(8'h0C, 32'd1, 4'hF);
      wr(8'h04, 32'h0, 4'hF);

      // One-shot without interrupt
      wr(8'h08, 32'd3, 4'hF);
      wr(8'h00, 32'h1, 4'hF);
      wait_cycles(6);
      rd(8'h00, 32'h0);
      rd(8'h04, 32'd3);
      rd(8'h0C, 32'd1);
      chk("oneshot_irq", {31'd0, irq}, 32'd0);
      wr(8'h0C, 32'd1, 4'hF);

      // Wrap and partial writes
      wr(8'h08, 32'h10, 4'hF);
      wr(8'h04, 32'hFFFFFFFE, 4'hF);
      wr(8'h00, 32'h1, 4'hF);
      rd(8'h04, 32'hFFFFFFFE);
      rd(8'h04, 32'hFFFFFFFF);
      rd(8'h04, 32'h0);
      rd(8'h0C, 32'h0);
      wr(8'h00, 32'h0, 4'hF);
      wr(8'h04, 32'h123456AA, 4'b0001);
      rd(8'h04, 32'h000000AA);
      wr(8'h04, 32'h00550000, 4'b0100);
      rd(8'h04, 32'h005500AA);

      // W1C in the same cycle as a match
      wr(8'h04, 32'h0, 4'hF);
      wr(8'h08, 32'd2, 4'hF);
      wr(8'h00, 32'h5, 4'hF);
      wait_cycles(2);
      wr(8'h0C, 32'd1, 4'hF);
      rd(8'h0C, 32'd1);
      chk("w1c_irq", {31'd0, irq}, 32'd1);
      rd(8'h00, 32'h4);
      rd(8'h04, 32'd2);

      // Out-of-window accesses
      bus_req  = 1'b1;
      bus_we   = 1'b0;
      bus_addr = BASE + 32'h40;
      #1;
      chk("oow_ack", {31'd0, bus_ack}, 32'd1);
      @(posedge clk);
      #1;
      idle();
      chk("oow_noresp", {31'd0, bus_resp}, 32'd0);
      chk("ack_idle", {31'd0, bus_ack}, 32'd0);
      cyc(1'b0, BASE - 32'd4, 4'h0, 32'h0);
      idle();
      chk("below_noresp", {31'd0, bus_resp}, 32'd0);
      cyc(1'b1, BASE + 32'h28, 4'hF, 32'hDEAD0000);
      idle();

      // Back-to-back reads
      rd_push(8'h08, 32'd2);
      rd_push(8'h00, 32'h4);
      rd_push(8'h14, 32'h0);
      rd_push(8'h1C, 32'h0);
      idle();

      // Prescaler
      wr(8'h0C, 32'd1, 4'hF);
      wr(8'h04, 32'h0, 4'hF);
      wr(8'h08, 32'd2, 4'hF);
      wr(8'h10, 32'd3, 4'hF);
`ifdef SIGMA_TIMER_PRESCALER_EN
      wr(8'h00, 32'h3, 4'hF);
      wait_cycles(10);
      rd(8'h0C, 32'd0);
      rd(8'h0C, 32'd0);
      rd(8'h0C, 32'd1);
      rd(8'h10, 32'd3);
`else
      rd(8'h10, 32'd0);
`endif
      wr(8'h00, 32'h0, 4'hF);

      // Reset while counting
      wr(8'h00, 32'h1, 4'hF);
      wait_cycles(3);
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      rd(8'h04, 32'h0);
      rd(8'h08, 32'hFFFFFFFF);
      rd(8'h00, 32'h0);
      chk("rst_mid_irq", {31'd0, irq}, 32'd0);

      for (int i = 0; i < 10 && sb.size() != 0; i++) begin
         @(posedge clk);
      end
      #1;
      chk("scoreboard_drain", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
